display_hamming: RTL and testbench
==================================

Name: display_hamming

Overview:
- Downstream consumer of the Hamming SECDED encode/decode stage.
- Drives a 4-digit multiplexed 7-segment display and the double-error LED.
- The display shows the corrected data, the syndrome, the original data and an error-status glyph.
- Inputs are snapshotted once per scan frame, so a digit never tears mid-frame.

Parameters:
- REFRESCO_CICLOS, 27000: clock cycles per digit slot. Must be ≥4.
- BLANCO_CICLOS, 16: blanking cycles at the start of each slot (anti-ghosting). Must be < REFRESCO_CICLOS.
- PARPADEO_CICLOS, 13500000: cycles per blink half-period. Must be ≥2.

Ports:
- reloj  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dato_entrada  in  4  original data nibble
- corregido  in  4  corrected data nibble from the decoder
- sindrome  in  3  {s3,s2,s1} from the decoder; 0 means no error
- error_simple  in  1  single-error flag
- error_doble  in  1  double-error flag
- anodos  out  4  digit enables, active-low; bit n = digit n
- segmentos  out  7  segments, active-low; bit0=a … bit6=g
- led_doblerror  out  1  blinking double-error indicator, active-high

Behaviour:
- Reset (sampled on reloj edge, rst=1):
  - cnt_ref=0, indice=0, cnt_parp=0, fase=0, all snapshot registers=0.
  - anodos=4'b1111, segmentos=7'h7F, led_doblerror=0.
  - Reset asserted mid-frame takes effect at the next edge; no partial digit remains.
- Refresh counter cnt_ref:
  - Counts 0..REFRESCO_CICLOS-1.
  - At terminal count it wraps to 0 and indice advances 0→1→2→3→0.
  - One frame = 4*REFRESCO_CICLOS cycles.
- Snapshot:
  - Captured on the edge where cnt_ref==REFRESCO_CICLOS-1 and indice==3 (frame boundary).
  - Registers captured: dato_entrada, corregido, sindrome, and an estado code.
  - estado code: 0 = no error; 1 = error_simple only; 2 = error_doble.
  - If error_simple and error_doble are both 1, treat as doble (estado=2).
  - Input changes between boundaries are ignored.
  - After reset, all digits show snapshot zero until the first boundary.
- Digit map (data shown as hex 0–F, standard glyphs):
  - digit0 = corregido.
  - digit1 = sindrome, zero-extended.
  - digit2 = dato_entrada.
  - digit3 = estado glyph: '0' for 0; '1' for 1.
  - For estado 2, digit3 shows 'd' (7'h21) when fase=1 and blank (7'h7F) when fase=0.
- Output registers (registered from the current indice/cnt_ref/snapshot, so one cycle of latency):
  - anodos: bit indice driven low only when cnt_ref ≥ BLANCO_CICLOS; otherwise all 1.
  - segmentos: the glyph for digit indice.
  - segmentos forced to 7'h7F while all anodes are off.
- Blink counter cnt_parp:
  - Free-running 0..PARPADEO_CICLOS-1.
  - fase toggles on the terminal-count edge.
  - Independent of the scan; cleared only by reset.
- led_doblerror: registered (snapshot estado==2) & fase.
- All counters wrap with no overflow states. Widths are sized via $clog2 of the respective parameter.

Test Plan (REFRESCO_CICLOS=8, BLANCO_CICLOS=2, PARPADEO_CICLOS=20):
- Reset: rst=1 for 3 cycles with arbitrary inputs → anodos=4'b1111, segmentos=7'h7F, led_doblerror=0 throughout and on the first cycle after release.
- Scan timing: after reset release, each slot shows anodos=4'b1111 for 2 cycles, then the enable pattern for 6 cycles. Enables appear as 1110, 1101, 1011, 0111 in that order; the pattern repeats every 32 cycles and never has two anodes low at once.
- Clean data: corregido=4'hA, dato_entrada=4'hA, sindrome=0, no flags, applied before the first boundary → from the second frame: digit0 and digit2 segmentos=7'h08, digit1=7'h40, digit3=7'h40, led_doblerror=0. During the first frame all digits read 7'h40.
- Single error: sindrome=3'd5, error_simple=1 → next frame: digit1=7'h12, digit3=7'h79, led_doblerror=0, no blinking.
- Double error: error_doble=1 (also with error_simple=1) → digit3 alternates 7'h21 and 7'h7F with a 20-cycle half-period. led_doblerror toggles in phase with the glyph (high exactly when 'd' is shown).
- Mid-frame change and reset:
  - Change corregido 4'hA→4'h3 while indice=1 → digit0 remains 7'h08 until after the next boundary, then shows 7'h30.
  - rst=1 for 1 cycle while indice=2 → outputs return to reset values on the next cycle; the scan restarts at digit0 with the snapshot cleared.

Source files
------------

// File: rtl/display_hamming.sv
// Scans the SECDED stage results onto a 4-digit multiplexed 7-segment display and
// drives a blinking double-error LED. Inputs are snapshotted once per scan frame.
module display_hamming #(
   parameter int unsigned REFRESCO_CICLOS = 27000,
   parameter int unsigned BLANCO_CICLOS   = 16,
   parameter int unsigned PARPADEO_CICLOS = 13500000
) (
   input  logic       reloj,
   input  logic       rst,
   input  logic [3:0] dato_entrada,
   input  logic [3:0] corregido,
   input  logic [2:0] sindrome,
   input  logic       error_simple,
   input  logic       error_doble,
   output logic [3:0] anodos,
   output logic [6:0] segmentos,
   output logic       led_doblerror
);

   localparam int unsigned RefW  = $clog2(REFRESCO_CICLOS);
   localparam int unsigned ParpW = $clog2(PARPADEO_CICLOS);

   localparam logic [RefW-1:0]  RefFin  = RefW'(REFRESCO_CICLOS - 1);
   localparam logic [RefW-1:0]  Blanco  = RefW'(BLANCO_CICLOS);
   localparam logic [ParpW-1:0] ParpFin = ParpW'(PARPADEO_CICLOS - 1);

   localparam logic [1:0] EstOk     = 2'd0;
   localparam logic [1:0] EstSimple = 2'd1;
   localparam logic [1:0] EstDoble  = 2'd2;

   logic [RefW-1:0]  r_cnt_ref;
   logic [1:0]       r_indice;
   logic [ParpW-1:0] r_cnt_parp;
   logic             r_fase;
   logic [3:0]       r_snap_dato;
   logic [3:0]       r_snap_corr;
   logic [2:0]       r_snap_sind;
   logic [1:0]       r_snap_estado;
   logic [3:0]       r_anodos;
   logic [6:0]       r_segmentos;
   logic             r_led;

   logic             w_fin_ref;
   logic             w_fin_parp;
   logic             w_frontera;
   logic [1:0]       w_estado;
   logic [6:0]       w_glifo;
   logic [3:0]       w_anodos;
   logic [6:0]       w_segmentos;

   // Active-low glyphs, bit0 = a ... bit6 = g.
   function automatic logic [6:0] f_hex(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   assign w_fin_ref  = (r_cnt_ref == RefFin);
   assign w_fin_parp = (r_cnt_parp == ParpFin);
   assign w_frontera = w_fin_ref && (r_indice == 2'd3);
   // Double error dominates when both flags are raised.
   assign w_estado   = error_doble ? EstDoble : (error_simple ? EstSimple : EstOk);

   always_comb begin
      w_glifo     = 7'h7F;
      w_anodos    = 4'b1111;
      w_segmentos = 7'h7F;
      unique case (r_indice)
         2'd0: w_glifo = f_hex(r_snap_corr);
         2'd1: w_glifo = f_hex({1'b0, r_snap_sind});
         2'd2: w_glifo = f_hex(r_snap_dato);
         2'd3: begin
            case (r_snap_estado)
               EstOk:     w_glifo = 7'h40;
               EstSimple: w_glifo = 7'h79;
               EstDoble:  w_glifo = r_fase ? 7'h21 : 7'h7F;
               default:   w_glifo = 7'h7F;
            endcase
         end
      endcase
      // Anti-ghosting: every anode stays off for the first cycles of each slot.
      if (r_cnt_ref >= Blanco) begin
         w_anodos    = ~(4'b0001 << r_indice);
         w_segmentos = w_glifo;
      end
   end

   always_ff @(posedge reloj) begin
      if (rst) begin
         r_cnt_ref     <= '0;
         r_indice      <= 2'd0;
         r_cnt_parp    <= '0;
         r_fase        <= 1'b0;
         r_snap_dato   <= 4'h0;
         r_snap_corr   <= 4'h0;
         r_snap_sind   <= 3'd0;
         r_snap_estado <= EstOk;
         r_anodos      <= 4'b1111;
         r_segmentos   <= 7'h7F;
         r_led         <= 1'b0;
      end else begin
         r_cnt_ref <= w_fin_ref ? '0 : r_cnt_ref + 1'b1;
         if (w_fin_ref) begin
            r_indice <= r_indice + 2'd1;
         end
         r_cnt_parp <= w_fin_parp ? '0 : r_cnt_parp + 1'b1;
         if (w_fin_parp) begin
            r_fase <= ~r_fase;
         end
         if (w_frontera) begin
            r_snap_dato   <= dato_entrada;
            r_snap_corr   <= corregido;
            r_snap_sind   <= sindrome;
            r_snap_estado <= w_estado;
         end
         r_anodos    <= w_anodos;
         r_segmentos <= w_segmentos;
         r_led       <= (r_snap_estado == EstDoble) && r_fase;
      end
   end

   assign anodos        = r_anodos;
   assign segmentos     = r_segmentos;
   assign led_doblerror = r_led;

endmodule

// File: tb/tb_display_hamming.sv
// Self-checking bench for display_hamming: a frame-position model predicts each output
// cycle, pushes the prediction to a queue, and it is popped and compared after the edge.
module tb_display_hamming;

   localparam int unsigned Ref   = 8;
   localparam int unsigned Blank = 2;
   localparam int unsigned Parp  = 20;

   logic       reloj;
   logic       rst;
   logic [3:0] dato_entrada;
   logic [3:0] corregido;
   logic [2:0] sindrome;
   logic       error_simple;
   logic       error_doble;
   logic [3:0] anodos;
   logic [6:0] segmentos;
   logic       led_doblerror;

   display_hamming #(
      .REFRESCO_CICLOS(Ref),
      .BLANCO_CICLOS  (Blank),
      .PARPADEO_CICLOS(Parp)
   ) dut (
      .reloj        (reloj),
      .rst          (rst),
      .dato_entrada (dato_entrada),
      .corregido    (corregido),
      .sindrome     (sindrome),
      .error_simple (error_simple),
      .error_doble  (error_doble),
      .anodos       (anodos),
      .segmentos    (segmentos),
      .led_doblerror(led_doblerror)
   );

   initial begin
      reloj = 1'b0;
      forever #5 reloj = ~reloj;
   end

   int errors = 0;
   int checks = 0;

   // Model state: edges since the last reset edge, plus the frame snapshot.
   int         n = 0;
   logic [3:0] m_dato = 4'h0;
   logic [3:0] m_corr = 4'h0;
   logic [2:0] m_sind = 3'd0;
   int         m_est  = 0;

   logic [11:0] exp_q[$];

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
         4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
         4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
         4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
      endcase
      return g;
   endfunction

   task automatic step();
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_led;
      logic [11:0] e;
      int          pos;
      int          slot;
      int          fase;
      e_an  = 4'b1111;
      e_seg = 7'h7F;
      e_led = 1'b0;
      if (!rst) begin
         pos   = n % Ref;
         slot  = (n / Ref) % 4;
         fase  = (n / Parp) % 2;
         e_led = (m_est == 2) && (fase == 1);
         if (pos >= Blank) begin
            e_an[slot] = 1'b0;
            case (slot)
               0: e_seg = glyph(m_corr);
               1: e_seg = glyph({1'b0, m_sind});
               2: e_seg = glyph(m_dato);
               default: e_seg = (m_est == 0) ? 7'h40 : (m_est == 1) ? 7'h79 :
                                (fase == 1) ? 7'h21 : 7'h7F;
            endcase
         end
      end
      exp_q.push_back({e_an, e_seg, e_led});
      if (rst) begin
         n = 0;
         m_dato = 4'h0;
         m_corr = 4'h0;
         m_sind = 3'd0;
         m_est  = 0;
      end else begin
         if ((n % (4 * Ref)) == (4 * Ref - 1)) begin
            m_dato = dato_entrada;
            m_corr = corregido;
            m_sind = sindrome;
            m_est  = error_doble ? 2 : (error_simple ? 1 : 0);
         end
         n++;
      end
      @(posedge reloj);
      #1;
      e = exp_q.pop_front();
      checks++;
      assert (anodos === e[11:8]) else begin
         errors++;
         $error("FAIL anodos n=%0d got=%b exp=%b", n, anodos, e[11:8]);
      end
      checks++;
      assert (segmentos === e[7:1]) else begin
         errors++;
         $error("FAIL segmentos n=%0d got=%h exp=%h", n, segmentos, e[7:1]);
      end
      checks++;
      assert (led_doblerror === e[0]) else begin
         errors++;
         $error("FAIL led_doblerror n=%0d got=%b exp=%b", n, led_doblerror, e[0]);
      end
      checks++;
      assert ($countones(~anodos) <= 1) else begin
         errors++;
         $error("FAIL one_hot_anode n=%0d got=%b exp=at most one low", n, anodos);
      end
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      rst          = 1'b1;
      dato_entrada = 4'h7;
      corregido    = 4'hC;
      sindrome     = 3'd6;
      error_simple = 1'b1;
      error_doble  = 1'b1;
      run(3);

      // Clean data applied before the first boundary.
      rst          = 1'b0;
      corregido    = 4'hA;
      dato_entrada = 4'hA;
      sindrome     = 3'd0;
      error_simple = 1'b0;
      error_doble  = 1'b0;
      run(64);

      // Single error.
      sindrome     = 3'd5;
      error_simple = 1'b1;
      run(64);

      // Double error, first with both flags, then double alone.
      error_doble = 1'b1;
      run(48);
      error_simple = 1'b0;
      run(48);

      // Back to clean, then change corregido while digit1 is being scanned.
      error_doble = 1'b0;
      sindrome    = 3'd0;
      run(32);
      while ((n % (4 * Ref)) != 12) step();
      corregido = 4'h3;
      run(64);

      // Mid-frame reset during digit2, with random inputs.
      while ((n % (4 * Ref)) != 20) step();
      rst          = 1'b1;
      corregido    = 4'($urandom_range(0, 15));
      dato_entrada = 4'($urandom_range(0, 15));
      sindrome     = 3'($urandom_range(0, 7));
      step();
      rst = 1'b0;
      run(72);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
